usb_line_monitor: RTL and testbench
===================================

# usb_line_monitor

USB full-speed line monitor that sits directly on the `usb_d_p`/`usb_d_n` pins and drives `usb_pullup`, operating in the `sys_clk` domain fed straight from `clk16`. It synchronises and glitch-filters the differential pair, reports the bus line state, and controls device attach via the pull-up. It detects host bus reset, suspend and resume, and feeds the future USB receive/protocol stages.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per pin (≥2).
- `FILTER_CYCLES`, 2: consecutive identical synced samples required before the filtered state changes (≥1).
- `CONNECT_CYCLES`, 16000: delay from enable to pull-up assertion (1 ms at 16 MHz).
- `RESET_CYCLES`, 40: consecutive filtered SE0 cycles that constitute a bus reset (2.5 µs).
- `SUSPEND_CYCLES`, 48000: consecutive filtered J cycles that constitute suspend (3 ms).
- `sys_clk  in  1`: single clock; all logic on its rising edge.
- `sys_rst  in  1`: synchronous, active-high reset.
- `usb_d_p  in  1`: raw D+ pin, asynchronous.
- `usb_d_n  in  1`: raw D− pin, asynchronous.
- `connect_en  in  1`: level; 1 requests attach, 0 forces detach.
- `usb_pullup  out  1`: D+ pull-up enable.
- `line_state  out  2`: filtered `{dp,dn}`; 10=J, 01=K, 00=SE0, 11=SE1.
- `bus_reset  out  1`: one-cycle pulse on entry to RESET.
- `in_reset  out  1`: level, high while in RESET.
- `suspend  out  1`: level, high while in SUSPEND.
- `resume  out  1`: one-cycle pulse on exit from SUSPEND.

## Operation
- Synchroniser: `SYNC_STAGES` flops per pin, reset to D+=1, D−=0.
- Filter: a stability counter tracks the synced pair. `line_state` takes the new value only after it has been identical for `FILTER_CYCLES` consecutive cycles. Any change restarts the count.
- Pin-to-`line_state` latency is `SYNC_STAGES + FILTER_CYCLES` cycles.
- A single shared duration counter has width `$clog2(max(CONNECT,RESET,SUSPEND)+1)`, which is 16 bits at the defaults. It saturates and never wraps.
- State machine, registered outputs:
  - DETACHED: pull-up 0. The counter increments while `connect_en`=1 and clears while it is 0. When the count reaches `CONNECT_CYCLES`, go to CONNECTED and clear the counter.
  - CONNECTED: pull-up 1.
    - The counter counts consecutive cycles of the same filtered state when that state is SE0 or J. It clears on any other state and restarts at 1 when the state changes between SE0 and J.
    - When the SE0 count reaches `RESET_CYCLES`, go to RESET.
    - When the J count reaches `SUSPEND_CYCLES`, go to SUSPEND.
  - RESET: `in_reset`=1. When the filtered state leaves SE0, go to CONNECTED and clear the counter.
  - SUSPEND: `suspend`=1. On any filtered state other than J, go to CONNECTED and pulse `resume`. If that state is SE0, the counter loads 1 so reset timing continues seamlessly.
- `connect_en`=0 in any state goes to DETACHED on the next edge. This takes priority over every other transition.
- SE1 is reported on `line_state` but treated as non-idle activity, so it clears the counter and exits SUSPEND.

## Timing
- Reset values on the edge where `sys_rst`=1:
  - `usb_pullup`=0, `line_state`=10 (J), `bus_reset`=0, `in_reset`=0, `suspend`=0, `resume`=0.
  - State DETACHED, counters 0.
- Reset mid-operation, including in RESET or SUSPEND, drops every output to the values above on that edge with no pulses emitted.
- With `connect_en` held at 1 from the first cycle after reset, `usb_pullup` rises exactly `CONNECT_CYCLES` cycles after `sys_rst` deasserts.
- `bus_reset` is high for exactly one cycle: the first cycle `in_reset` is high. That is the cycle after the `RESET_CYCLES`-th consecutive filtered SE0.
- `resume` is high in the first cycle after `suspend` falls.
- `resume` and `bus_reset` are never high in the same cycle.

## Structure
- Package `usb_line_pkg`:
  - Line-state constants `LS_J`, `LS_K`, `LS_SE0`, `LS_SE1`.
  - State enum for DETACHED, CONNECTED, RESET, SUSPEND.
- Sub-module `usb_line_filter` contains the synchroniser and glitch filter, and outputs `line_state`. The top-level `usb_line_monitor` holds the FSM and the duration counter.

## Test plan
- Attach: release `sys_rst`, hold `connect_en`=1 → `usb_pullup` is 0 for cycles 1..15999 and 1 at cycle 16000; a mid-count `connect_en`=0 restarts the count.
- Glitch: in CONNECTED with J, drive SE0 for 1 cycle → `line_state` stays 10; drive SE0 for 2 cycles → `line_state`=00 after 4 cycles.
- Bus reset boundary: filtered SE0 for 39 cycles then J → no `bus_reset`. SE0 for 40 cycles → one `bus_reset` pulse and `in_reset` high; on return to J, `in_reset` falls after filter latency.
- Suspend/resume: J for 48000 filtered cycles → `suspend`=1; drive K → `suspend` falls and `resume` pulses once. Drive SE0 instead, held for 39 more cycles → `bus_reset` fires.
- Reset mid-operation: assert `sys_rst` for 1 cycle while `suspend`=1 → next edge all outputs at reset values, `usb_pullup`=0, no `resume` pulse.
- Detach: `connect_en`→0 while in RESET → next edge `usb_pullup`=0 and `in_reset`=0.

Source files
------------

// File: rtl/usb_line_pkg.sv
// rtl/usb_line_pkg.sv - line-state constants and monitor FSM states
package usb_line_pkg;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {
        ST_DETACHED,
        ST_CONNECTED,
        ST_RESET,
        ST_SUSPEND
    } line_fsm_t;

endpackage

// File: rtl/usb_line_monitor_if.sv
// rtl/usb_line_monitor_if.sv - pin, attach and bus-event signals of the line monitor
interface usb_line_monitor_if;

    logic       usb_d_p;
    logic       usb_d_n;
    logic       connect_en;
    logic       usb_pullup;
    logic [1:0] line_state;
    logic       bus_reset;
    logic       in_reset;
    logic       suspend;
    logic       resume;

    modport master (
        input  usb_d_p, usb_d_n, connect_en,
        output usb_pullup, line_state, bus_reset, in_reset, suspend, resume
    );

    modport slave (
        output usb_d_p, usb_d_n, connect_en,
        input  usb_pullup, line_state, bus_reset, in_reset, suspend, resume
    );

endinterface

// File: rtl/usb_line_filter.sv
// rtl/usb_line_filter.sv - D+/D- synchroniser and stability glitch filter
module usb_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic [1:0] line_state
);
    import usb_line_pkg::*;

    localparam int            FW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW:0]   FILT = (FW + 1)'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] dp_sync;
    logic [SYNC_STAGES-1:0] dn_sync;
    logic [1:0]             synced;
    logic [1:0]             cand;
    logic [FW-1:0]          run;
    logic [FW:0]            run_next;

    assign synced = {dp_sync[SYNC_STAGES-1], dn_sync[SYNC_STAGES-1]};

    // run_next is the length of the identical-sample run including this cycle
    always_comb begin
        run_next = {{FW{1'b0}}, 1'b1};
        if (synced == cand) begin
            run_next = {1'b0, run} + {{FW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dp_sync    <= '1;
            dn_sync    <= '0;
            cand       <= LS_J;
            run        <= FILT[FW-1:0];
            line_state <= LS_J;
        end else begin
            dp_sync <= {dp_sync[SYNC_STAGES-2:0], usb_d_p};
            dn_sync <= {dn_sync[SYNC_STAGES-2:0], usb_d_n};
            cand    <= synced;
            run     <= (run_next >= FILT) ? FILT[FW-1:0] : run_next[FW-1:0];
            if (run_next >= FILT) begin
                line_state <= synced;
            end
        end
    end

endmodule

// File: rtl/usb_line_monitor.sv
// rtl/usb_line_monitor.sv - attach control and bus reset/suspend/resume detection
module usb_line_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 2,
    parameter int CONNECT_CYCLES = 16000,
    parameter int RESET_CYCLES   = 40,
    parameter int SUSPEND_CYCLES = 48000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    usb_line_monitor_if.master bus
);
    import usb_line_pkg::*;

    localparam int MAX_RS = (RESET_CYCLES > SUSPEND_CYCLES) ? RESET_CYCLES : SUSPEND_CYCLES;
    localparam int MAXC   = (CONNECT_CYCLES > MAX_RS) ? CONNECT_CYCLES : MAX_RS;
    localparam int CW     = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CONNECT_N = CW'(CONNECT_CYCLES);
    localparam logic [CW-1:0] RESET_N   = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] SUSPEND_N = CW'(SUSPEND_CYCLES);

    line_fsm_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    ls, prev_ls;
    logic          pullup_q, bus_reset_q, in_reset_q, suspend_q, resume_q;
    logic          pullup_n, bus_reset_n, in_reset_n, suspend_n, resume_n;

    usb_line_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .usb_d_p   (bus.usb_d_p),
        .usb_d_n   (bus.usb_d_n),
        .line_state(ls)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!bus.connect_en) begin
            state_n = ST_DETACHED;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_DETACHED: begin
                    cnt_n = cnt_inc;
                    if (cnt_inc >= CONNECT_N) begin
                        state_n = ST_CONNECTED;
                        cnt_n   = '0;
                    end
                end
                ST_CONNECTED: begin
                    if (ls == LS_SE0 || ls == LS_J) begin
                        cnt_n = (ls == prev_ls) ? cnt_inc : CW'(1);
                        if (ls == LS_SE0 && cnt_n >= RESET_N) begin
                            state_n = ST_RESET;
                        end else if (ls == LS_J && cnt_n >= SUSPEND_N) begin
                            state_n = ST_SUSPEND;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                ST_RESET: begin
                    if (ls != LS_SE0) begin
                        state_n = ST_CONNECTED;
                        cnt_n   = '0;
                    end
                end
                ST_SUSPEND: begin
                    // leaving on SE0 counts that cycle toward a following bus reset
                    if (ls != LS_J) begin
                        state_n = ST_CONNECTED;
                        cnt_n   = (ls == LS_SE0) ? CW'(1) : '0;
                    end
                end
                default: begin
                    state_n = ST_DETACHED;
                    cnt_n   = '0;
                end
            endcase
        end

        pullup_n    = (state_n != ST_DETACHED);
        in_reset_n  = (state_n == ST_RESET);
        suspend_n   = (state_n == ST_SUSPEND);
        bus_reset_n = (state_n == ST_RESET) && (state != ST_RESET);
        resume_n    = (state == ST_SUSPEND) && (state_n == ST_CONNECTED);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_DETACHED;
            cnt         <= '0;
            prev_ls     <= LS_J;
            pullup_q    <= 1'b0;
            bus_reset_q <= 1'b0;
            in_reset_q  <= 1'b0;
            suspend_q   <= 1'b0;
            resume_q    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            prev_ls     <= ls;
            pullup_q    <= pullup_n;
            bus_reset_q <= bus_reset_n;
            in_reset_q  <= in_reset_n;
            suspend_q   <= suspend_n;
            resume_q    <= resume_n;
        end
    end

    assign bus.usb_pullup = pullup_q;
    assign bus.line_state = ls;
    assign bus.bus_reset  = bus_reset_q;
    assign bus.in_reset   = in_reset_q;
    assign bus.suspend    = suspend_q;
    assign bus.resume     = resume_q;

endmodule

// File: tb/tb_usb_line_monitor.sv
// tb/tb_usb_line_monitor.sv - self-checking bench for usb_line_monitor
module tb_usb_line_monitor;
    import usb_line_pkg::*;

    localparam int SYNC = 2;
    localparam int FILT = 2;
    localparam int CONN = 16000;
    localparam int RST  = 40;
    localparam int SUS  = 3000;

    localparam int M_DET  = 0;
    localparam int M_CONN = 1;
    localparam int M_RST  = 2;
    localparam int M_SUS  = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    usb_line_monitor_if ifc();

    usb_line_monitor #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT),
        .CONNECT_CYCLES(CONN),
        .RESET_CYCLES  (RST),
        .SUSPEND_CYCLES(SUS)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (ifc.master)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: pin history plus timestamps of run starts and state entries
    logic [1:0] hist[$];
    logic [1:0] m_ls;
    int         m_state, m_now, m_base, m_run_start, m_cen_start;
    logic [6:0] m_out;

    int n_br, n_res;
    bit saw_se0;

    typedef struct {
        logic [1:0] pins;
        int         len;
        int         exp_br;
        bit         exp_se0;
    } vec_t;
    vec_t tbl[7];

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic rst, input logic [1:0] pins, input logic cen);
        int ns, c, n;
        bit stable;
        m_now++;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < SYNC + FILT; i++) hist.push_back(LS_J);
            m_state     = M_DET;
            m_base      = m_now + 1;
            m_ls        = LS_J;
            m_run_start = m_now + 1;
            m_cen_start = m_now + 1;
            m_out       = {1'b0, LS_J, 4'b0000};
            return;
        end
        hist.push_back(pins);
        if (hist.size() > 32) void'(hist.pop_front());
        if (!cen) m_cen_start = m_now + 1;

        ns = m_state;
        if (!cen) ns = M_DET;
        else begin
            case (m_state)
                M_DET:  if (m_now - max2(m_cen_start, m_base) + 1 >= CONN) ns = M_CONN;
                M_CONN: begin
                    c = m_now - max2(m_run_start, m_base) + 1;
                    if (m_ls == LS_SE0 && c >= RST) ns = M_RST;
                    else if (m_ls == LS_J && c >= SUS) ns = M_SUS;
                end
                M_RST:  if (m_ls != LS_SE0) ns = M_CONN;
                M_SUS:  if (m_ls != LS_J) ns = M_CONN;
                default: ns = M_DET;
            endcase
        end
        if (ns != m_state && (ns == M_CONN || ns == M_DET))
            m_base = (m_state == M_SUS && ns == M_CONN && m_ls == LS_SE0) ? m_now : m_now + 1;

        n = hist.size();
        stable = 1;
        for (int i = 1; i < FILT; i++)
            if (hist[n-1-SYNC-i] != hist[n-1-SYNC]) stable = 0;
        if (stable && hist[n-1-SYNC] != m_ls) begin
            m_ls        = hist[n-1-SYNC];
            m_run_start = m_now + 1;
        end

        m_out = {ns != M_DET, m_ls, (ns == M_RST) && (m_state != M_RST), ns == M_RST,
                 ns == M_SUS, (m_state == M_SUS) && (ns == M_CONN)};
        m_state = ns;
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge(sys_rst, {ifc.usb_d_p, ifc.usb_d_n}, ifc.connect_en);
        #1;
        chk("cycle_outputs", {ifc.usb_pullup, ifc.line_state, ifc.bus_reset, ifc.in_reset,
                              ifc.suspend, ifc.resume}, m_out);
        if (ifc.bus_reset) n_br++;
        if (ifc.resume) n_res++;
        if (ifc.line_state == LS_SE0) saw_se0 = 1;
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        {ifc.usb_d_p, ifc.usb_d_n} = v;
        repeat (n) step();
    endtask

    task automatic wait_attach(input string name);
        int lat = 0;
        while (!ifc.usb_pullup && lat < CONN + 4000) begin
            step();
            lat++;
        end
        chk(name, lat, CONN);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] v;
        int r;
        {ifc.usb_d_p, ifc.usb_d_n} = LS_J;
        ifc.connect_en = 1'b0;
        sys_rst = 1'b1;
        step();
        chk("reset_state", {ifc.usb_pullup, ifc.line_state, ifc.bus_reset, ifc.in_reset,
                            ifc.suspend, ifc.resume}, {1'b0, LS_J, 4'b0000});
        step();
        sys_rst = 1'b0;
        ifc.connect_en = 1'b1;
        wait_attach("attach_latency");

        // two-cycle SE0 reaches line_state exactly SYNC+FILT edges after it starts
        drive(LS_J, 10);
        drive(LS_SE0, 2);
        {ifc.usb_d_p, ifc.usb_d_n} = LS_J;
        step();
        chk("glitch_lat3", ifc.line_state, LS_J);
        step();
        chk("glitch_lat4", ifc.line_state, LS_SE0);
        drive(LS_J, 10);

        tbl[0] = '{LS_SE0, 1, 0, 0};
        tbl[1] = '{LS_SE0, 2, 0, 1};
        tbl[2] = '{LS_SE0, 39, 0, 1};
        tbl[3] = '{LS_SE0, 40, 1, 1};
        tbl[4] = '{LS_SE0, 41, 1, 1};
        tbl[5] = '{LS_K, 5, 0, 0};
        tbl[6] = '{LS_SE1, 3, 0, 0};
        for (int i = 0; i < 7; i++) begin
            n_br = 0;
            saw_se0 = 0;
            drive(tbl[i].pins, tbl[i].len);
            drive(LS_J, 10);
            chk($sformatf("vec%0d_bus_reset", i), n_br, tbl[i].exp_br);
            chk($sformatf("vec%0d_se0_seen", i), saw_se0, tbl[i].exp_se0);
            chk($sformatf("vec%0d_in_reset_low", i), ifc.in_reset, 0);
        end

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            v = (r < 5) ? LS_J : (r < 7) ? LS_SE0 : (r < 9) ? LS_K : LS_SE1;
            drive(v, $urandom_range(1, 60));
        end

        drive(LS_J, SUS + 20);
        chk("suspend_set", ifc.suspend, 1);
        n_res = 0;
        drive(LS_K, 4);
        drive(LS_J, 10);
        chk("resume_pulses", n_res, 1);
        chk("suspend_cleared", ifc.suspend, 0);

        drive(LS_J, SUS + 20);
        chk("suspend_set2", ifc.suspend, 1);
        n_res = 0;
        n_br = 0;
        drive(LS_SE0, 41);
        drive(LS_J, 10);
        chk("resume_then_reset_res", n_res, 1);
        chk("resume_then_reset_br", n_br, 1);

        drive(LS_J, SUS + 20);
        chk("suspend_set3", ifc.suspend, 1);
        sys_rst = 1'b1;
        n_res = 0;
        step();
        chk("midop_reset", {ifc.usb_pullup, ifc.line_state, ifc.bus_reset, ifc.in_reset,
                            ifc.suspend, ifc.resume}, {1'b0, LS_J, 4'b0000});
        sys_rst = 1'b0;
        drive(LS_J, 100);
        ifc.connect_en = 1'b0;
        step();
        ifc.connect_en = 1'b1;
        wait_attach("reattach_latency");
        chk("no_resume_after_rst", n_res, 0);

        drive(LS_SE0, 50);
        chk("in_reset_before_detach", ifc.in_reset, 1);
        ifc.connect_en = 1'b0;
        step();
        chk("detach", {ifc.usb_pullup, ifc.in_reset}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
